ahb2apb_bridge: RTL and testbench

AHB-lite slave to APB4 master bridge; the stage directly upstream of apb_demux.
- Converts each single AHB transfer into one APB SETUP/ACCESS sequence.
- Drives the demux's paddr/psel/penable/pwrite/pwdata/pwstrb and returns pready/prdata/pslverr to AHB as hreadyout/hrdata/hresp.
- No bursts are optimised: every beat is a separate APB access.

---
 rtl/ahb2apb_bridge_pkg.sv | 24 ++
 rtl/ahb2apb_bridge.sv | 100 ++++++++++
 tb/tb_ahb2apb_bridge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb2apb_bridge_pkg.sv
// ahb2apb_bridge_pkg: AHB/APB codes, bridge state encoding and the strobe/alignment helpers.
package ahb2apb_bridge_pkg;
    localparam int P_ADDR_W = 32;
    localparam int P_DATA_W = 32;
    localparam int P_STRB_W = 4;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;
    function automatic logic f_legal(input logic [2:0] size, input logic [1:0] lo);
        return (size == HSIZE_BYTE) || (size == HSIZE_HALF && !lo[0]) || (size == HSIZE_WORD && lo == 2'b00);
    endfunction
    function automatic logic [P_STRB_W-1:0] f_strb(input logic [2:0] size, input logic [1:0] lo);
        return size == HSIZE_BYTE ? 4'b0001 << lo : size == HSIZE_HALF ? 4'b0011 << {lo[1], 1'b0} : 4'hF;
    endfunction
endpackage

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-lite slave to APB4 master, one SETUP/ACCESS per AHB beat.
// Define APB_BRIDGE_TIMEOUT_EN to abort ACCESS into an error after TIMEOUT_CYCLES without pready.
module ahb2apb_bridge
    import ahb2apb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                hsel,
    input  logic [P_ADDR_W-1:0] haddr,
    input  logic [1:0]          htrans,
    input  logic                hwrite,
    input  logic [2:0]          hsize,
    input  logic [P_DATA_W-1:0] hwdata,
    input  logic                hready,
    output logic                hreadyout,
    output logic                hresp,
    output logic [P_DATA_W-1:0] hrdata,
    output logic [P_ADDR_W-1:0] paddr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [P_DATA_W-1:0] pwdata,
    output logic [P_STRB_W-1:0] pwstrb,
    input  logic                pready,
    input  logic [P_DATA_W-1:0] prdata,
    input  logic                pslverr
);
    state_t              r_state, w_next;
    logic [P_ADDR_W-1:0] r_paddr;
    logic                r_pwrite;
    logic [P_STRB_W-1:0] r_pwstrb;
    logic [P_DATA_W-1:0] r_hrdata;
    logic                w_cap, w_legal, w_timeout;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    assign w_cap   = hsel & htrans[1] & hready & (r_state == ST_IDLE || r_state == ST_ERR2);
    assign w_legal = f_legal(hsize, haddr[1:0]);

`ifdef APB_BRIDGE_TIMEOUT_EN
    logic [15:0] r_cnt;
    // Held at zero outside ACCESS, so every ACCESS entry starts a fresh count.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            r_cnt <= '0;
        else if (r_state != ST_ACCESS)
            r_cnt <= '0;
        else if (!pready)
            r_cnt <= r_cnt + 16'd1;
    end
    assign w_timeout = (r_state == ST_ACCESS) & !pready & (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR2: w_next = w_cap ? (w_legal ? ST_SETUP : ST_ERR1) : ST_IDLE;
            ST_SETUP:         w_next = ST_ACCESS;
            ST_ACCESS:        w_next = pready ? (pslverr ? ST_ERR1 : ST_IDLE) : (w_timeout ? ST_ERR1 : ST_ACCESS);
            ST_ERR1:          w_next = ST_ERR2;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state  <= ST_IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwstrb <= '0;
            r_hrdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_cap) begin
                r_paddr  <= haddr;
                r_pwrite <= hwrite;
                r_pwstrb <= hwrite ? f_strb(hsize, haddr[1:0]) : '0;
            end
            if (r_state == ST_ACCESS && pready && !pslverr && !r_pwrite)
                r_hrdata <= prdata;
        end
    end

    // Handshake outputs decode straight from state so an async reset drops psel/penable at once.
    assign psel      = (r_state == ST_SETUP) | (r_state == ST_ACCESS);
    assign penable   = r_state == ST_ACCESS;
    assign hreadyout = (r_state == ST_IDLE) | (r_state == ST_ERR2);
    assign hresp     = (r_state == ST_ERR1) | (r_state == ST_ERR2);
    assign hrdata    = r_hrdata;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwstrb    = r_pwstrb;
    assign pwdata    = hwdata;
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: randomized AHB transfers against a transaction-timeline model of the bridge.
module tb_ahb2apb_bridge;
    import ahb2apb_bridge_pkg::*;
    localparam int TO = 8;
`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        pclk = 1'b0, preset = 1'b1;
    logic        hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
    logic [31:0] haddr = '0, hwdata = '0, prdata = '0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [2:0]  hsize = HSIZE_BYTE;
    logic        pready = 1'b0, pslverr = 1'b0;
    logic        hreadyout, hresp, psel, penable, pwrite;
    logic [31:0] hrdata, paddr, pwdata;
    logic [3:0]  pwstrb;

    int checks = 0, failures = 0;
    logic chk_en = 1'b0;
    logic e_hreadyout, e_hresp, e_psel, e_penable, e_pwrite;
    logic [31:0] e_paddr, e_hrdata;
    logic [3:0] e_pwstrb;
    logic m_err2 = 1'b0;
    logic [31:0] m_hrdata = '0;
    int mon_low = 0, mon_resp = 0, mon_sel = 0, mon_acc = 0;
    logic [3:0] mon_strb = '0;

    ahb2apb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .preset(preset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic exp_rest();
        e_hreadyout = 1'b1;
        e_hresp     = m_err2;
        e_psel      = 1'b0;
        e_penable   = 1'b0;
        e_hrdata    = m_hrdata;
    endtask

    task automatic exp_err1();
        e_hreadyout = 1'b0;
        e_hresp     = 1'b1;
        e_psel      = 1'b0;
        e_penable   = 1'b0;
        e_hrdata    = m_hrdata;
    endtask

    task automatic bus_noise();
        hready  = 1'b0;
        hsel    = 1'($urandom);
        htrans  = 2'($urandom);
        haddr   = $urandom;
        hwrite  = 1'($urandom);
        hsize   = 3'($urandom);
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
    endtask

    // One cycle with no valid request: deselected, IDLE/BUSY, or not qualified by hready.
    task automatic idle_cycle();
        int k;
        k = int'($urandom_range(0, 3));
        hsel   = (k != 0);
        htrans = (k == 1) ? HTRANS_IDLE : (k == 2) ? 2'b01 : HTRANS_NONSEQ;
        hready = (k != 3);
        haddr  = $urandom;
        hwrite = 1'($urandom);
        hsize  = 3'($urandom);
        hwdata = $urandom;
        pready = 1'($urandom);
        exp_rest();
        step();
        m_err2 = 1'b0;
    endtask

    // One AHB beat; the model lays out the expected cycle timeline from the transfer's attributes.
    task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input int stalls, input logic err, input logic [31:0] rd);
        int lo, nb;
        logic legal, fail;
        logic [3:0] strb;
        lo    = int'(a[1:0]);
        nb    = (sz <= 3'd2) ? (1 << sz) : 8;
        legal = (sz <= 3'd2) && (lo % nb == 0);
        strb  = '0;
        for (int i = 0; i < 4; i++)
            strb[i] = wr && (i >= lo) && (i < lo + nb);
        hsel   = 1'b1;
        htrans = $urandom_range(0, 1) ? HTRANS_NONSEQ : 2'b11;
        hready = 1'b1;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
        hwdata = $urandom;
        pready = 1'($urandom);
        exp_rest();
        step();
        bus_noise();
        hwdata = wd;
        if (!legal) begin
            exp_err1();
            step();
            m_err2 = 1'b1;
            return;
        end
        m_err2 = 1'b0;
        e_hreadyout = 1'b0;
        e_hresp     = 1'b0;
        e_psel      = 1'b1;
        e_penable   = 1'b0;
        e_paddr     = a;
        e_pwrite    = wr;
        e_pwstrb    = strb;
        e_hrdata    = m_hrdata;
        step();
        fail = 1'b0;
        for (int i = 0; i <= stalls; i++) begin
            bus_noise();
            hwdata  = wd;
            pready  = (i == stalls);
            pslverr = pready ? err : 1'($urandom);
            prdata  = pready ? rd : $urandom;
            e_penable = 1'b1;
            step();
            if (pready) begin
                fail = err;
                break;
            end
            if (TO_EN && i == TO - 1) begin
                fail = 1'b1;
                break;
            end
        end
        bus_noise();
        hwdata = wd;
        if (fail) begin
            exp_err1();
            step();
            m_err2 = 1'b1;
        end else if (!wr) begin
            m_hrdata = rd;
        end
    endtask

    initial begin
        int b0, b1, b2;
        #1;
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_pwstrb", 32'(pwstrb), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        step();
        preset = 1'b0;
        exp_rest();
        chk_en = 1'b1;
        fork
            forever begin
                @(negedge pclk);
                if (chk_en) begin
                    chk("hreadyout", 32'(hreadyout), 32'(e_hreadyout));
                    chk("hresp", 32'(hresp), 32'(e_hresp));
                    chk("psel", 32'(psel), 32'(e_psel));
                    chk("penable", 32'(penable), 32'(e_penable));
                    chk("hrdata", hrdata, e_hrdata);
                    chk("pwdata", pwdata, hwdata);
                    if (e_psel) begin
                        chk("paddr", paddr, e_paddr);
                        chk("pwrite", 32'(pwrite), 32'(e_pwrite));
                        chk("pwstrb", 32'(pwstrb), 32'(e_pwstrb));
                    end
                end
                mon_low  += int'(!hreadyout);
                mon_resp += int'(hresp);
                mon_sel  += int'(psel);
                mon_acc  += int'(psel && penable);
                if (psel && !penable)
                    mon_strb = pwstrb;
            end
        join_none
        idle_cycle();
        b0 = mon_low;
        xfer(1'b1, HSIZE_WORD, 32'h1000_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        idle_cycle();
        chk("word_wr_wait_states", 32'(mon_low - b0), 32'd2);
        chk("word_wr_strb", 32'(mon_strb), 32'hF);
        xfer(1'b1, HSIZE_BYTE, 32'h1000_0003, 32'h1122_3344, 1, 1'b0, 32'h0);
        chk("byte_wr_strb", 32'(mon_strb), 32'b1000);
        xfer(1'b1, HSIZE_HALF, 32'h1000_0002, 32'h5566_7788, 0, 1'b0, 32'h0);
        chk("half_wr_strb", 32'(mon_strb), 32'b1100);
        b0 = mon_low;
        xfer(1'b0, HSIZE_WORD, 32'h1000_0010, 32'h0, 3, 1'b0, 32'h1234_5678);
        chk("rd_wait_states", 32'(mon_low - b0), 32'd5);
        chk("rd_hrdata", hrdata, 32'h1234_5678);
        b0 = mon_low;
        b1 = mon_resp;
        xfer(1'b0, HSIZE_WORD, 32'h1000_0020, 32'h0, 0, 1'b1, 32'hAAAA_5555);
        idle_cycle();
        chk("err_resp_cycles", 32'(mon_resp - b1), 32'd2);
        chk("err_low_cycles", 32'(mon_low - b0), 32'd3);
        chk("err_hrdata_kept", hrdata, 32'h1234_5678);
        b1 = mon_resp;
        b2 = mon_sel;
        xfer(1'b1, HSIZE_WORD, 32'h1000_0002, 32'h0BAD_0BAD, 0, 1'b0, 32'h0);
        chk("misalign_no_psel", 32'(mon_sel - b2), 32'd0);
        xfer(1'b0, HSIZE_WORD, 32'h1000_0008, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        chk("misalign_resp_cycles", 32'(mon_resp - b1), 32'd2);
        chk("b2b_hrdata", hrdata, 32'hCAFE_F00D);
`ifdef APB_BRIDGE_TIMEOUT_EN
        b0 = mon_acc;
        b1 = mon_resp;
        xfer(1'b1, HSIZE_WORD, 32'h3000_0000, 32'h0, 20, 1'b0, 32'h0);
        idle_cycle();
        chk("timeout_access_cycles", 32'(mon_acc - b0), 32'd8);
        chk("timeout_resp_cycles", 32'(mon_resp - b1), 32'd2);
`endif
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0)
                idle_cycle();
            else
                xfer(1'($urandom), 3'($urandom_range(0, 3)), $urandom, $urandom,
                     int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, $urandom);
        end
        idle_cycle();
        chk_en = 1'b0;
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hready = 1'b1;
        haddr  = 32'h2000_0010;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        pready = 1'b0;
        step();
        hready = 1'b0;
        htrans = HTRANS_IDLE;
        step();
        chk("mid_psel", 32'(psel), 32'd1);
        chk("mid_penable", 32'(penable), 32'd1);
        #2 preset = 1'b1;
        #1;
        chk("abort_psel", 32'(psel), 32'd0);
        chk("abort_penable", 32'(penable), 32'd0);
        chk("abort_hreadyout", 32'(hreadyout), 32'd1);
        chk("abort_hrdata", hrdata, 32'd0);
        step();
        preset   = 1'b0;
        m_err2   = 1'b0;
        m_hrdata = '0;
        exp_rest();
        chk_en = 1'b1;
        for (int n = 0; n < 20; n++)
            xfer(1'($urandom), 3'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFFC, $urandom,
                 int'($urandom_range(0, 2)), 1'b0, $urandom);
        idle_cycle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
